// File: rtl/mem_port_arbiter.sv
// Two-port (fetch / load-store) arbiter in front of a single-ported memory.
// Define ARB_DATA_PRIORITY_EN for fixed D-priority ties; default is round-robin.
module mem_port_arbiter #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic [31:0] m_addr,
  output logic [1:0]  m_size,
  output logic [31:0] m_wdata,
  output logic        m_we,
  input  logic [31:0] m_rdata,
  output logic        busy
);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic        r_last_d;
  logic        r_own_d;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_size;
  logic        r_we;
  logic        r_i_rvalid;
  logic        r_d_rvalid;
  logic [31:0] r_i_rdata;
  logic [31:0] r_d_rdata;
  logic        w_d_win;
  logic        w_i_win;
  logic        w_grant;
  logic        w_done;

`ifdef ARB_DATA_PRIORITY_EN
  assign w_d_win = d_req;
`else
  // On a tie the port that did not own the previous transaction wins.
  assign w_d_win = d_req & (~i_req | ~r_last_d);
`endif
  assign w_i_win = i_req & ~w_d_win;
  assign w_grant = (r_state == S_IDLE) & ~rst & (i_req | d_req);
  assign w_done  = (r_state == S_BUSY) & (r_cnt == 4'd0);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (i_req | d_req) w_next = S_BUSY;
      S_BUSY: if (r_cnt == 4'd0) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    i_gnt   = 1'b0;
    d_gnt   = 1'b0;
    busy    = 1'b0;
    m_addr  = 32'd0;
    m_size  = 2'd0;
    m_wdata = 32'd0;
    m_we    = 1'b0;
    case (r_state)
      S_IDLE: begin
        i_gnt = ~rst & w_i_win;
        d_gnt = ~rst & w_d_win;
      end
      S_BUSY: begin
        busy    = 1'b1;
        m_addr  = r_addr;
        m_size  = r_size;
        m_wdata = r_wdata;
        // Single write strobe in the final cycle; a reset here kills it.
        m_we    = r_we & (r_cnt == 4'd0) & ~rst;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= 4'd0;
      r_last_d   <= 1'b1;
      r_own_d    <= 1'b0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_size     <= 2'd0;
      r_we       <= 1'b0;
      r_i_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      r_i_rdata  <= 32'd0;
      r_d_rdata  <= 32'd0;
    end else begin
      r_i_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      if (w_grant) begin
        r_own_d  <= w_d_win;
        r_last_d <= w_d_win;
        r_cnt    <= LAT_M1;
        r_addr   <= w_d_win ? d_addr : i_addr;
        r_size   <= w_d_win ? d_size : 2'b10;
        r_we     <= w_d_win & d_we;
        r_wdata  <= w_d_win ? d_wdata : 32'd0;
      end else if (w_done) begin
        if (r_own_d) begin
          r_d_rdata  <= r_we ? 32'd0 : m_rdata;
          r_d_rvalid <= 1'b1;
        end else begin
          r_i_rdata  <= m_rdata;
          r_i_rvalid <= 1'b1;
        end
      end else if (r_state == S_BUSY) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  assign i_rvalid = r_i_rvalid;
  assign d_rvalid = r_d_rvalid;
  assign i_rdata  = r_i_rdata;
  assign d_rdata  = r_d_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then random traffic,
// every cycle compared against a transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
  logic [1:0]  d_size;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, m_we, busy;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic [1:0]  m_size;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_addr(m_addr), .m_size(m_size), .m_wdata(m_wdata), .m_we(m_we), .m_rdata(m_rdata),
    .busy(busy)
  );

  logic [31:0] mem [0:255];
  bit          rand_rd;
  int          n_vec = 0;
  int          n_err = 0;
  bit          gq[$];

  // reference model: remaining busy cycles plus the accepted transaction
  int          rem;
  bit          own_d, last_d, l_we;
  logic [31:0] l_addr, l_wdata;
  logic [1:0]  l_size;
  bit          e_irv, e_drv;
  logic [31:0] e_ird, e_drd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    bit eg_i, eg_d;
    logic [31:0] val;
    #1;
    m_rdata = rand_rd ? $urandom : mem[m_addr[9:2]];
    #1;
    eg_i = 0;
    eg_d = 0;
    if (rem == 0 && !rst) begin
      if (i_req && d_req) begin
`ifdef ARB_DATA_PRIORITY_EN
        eg_d = 1;
`else
        if (last_d) eg_i = 1;
        else        eg_d = 1;
`endif
      end else if (i_req) eg_i = 1;
      else if (d_req)     eg_d = 1;
    end
    chk("i_gnt", i_gnt, eg_i);
    chk("d_gnt", d_gnt, eg_d);
    chk("busy", busy, rem > 0);
    chk("m_addr", m_addr, rem > 0 ? l_addr : 32'd0);
    chk("m_size", m_size, rem > 0 ? l_size : 2'd0);
    chk("m_wdata", m_wdata, rem > 0 ? l_wdata : 32'd0);
    chk("m_we", m_we, rem == 1 && l_we && !rst);
    chk("i_rvalid", i_rvalid, e_irv);
    chk("d_rvalid", d_rvalid, e_drv);
    chk("i_rdata", i_rdata, e_ird);
    chk("d_rdata", d_rdata, e_drd);
    if (i_gnt) gq.push_back(1'b0);
    if (d_gnt) gq.push_back(1'b1);
    if (m_we) mem[m_addr[9:2]] = m_wdata;
    val = l_we ? 32'd0 : m_rdata;
    @(posedge clk);
    e_irv = 0;
    e_drv = 0;
    if (rst) begin
      rem = 0; last_d = 1; e_ird = 0; e_drd = 0;
    end else if (rem == 0) begin
      if (eg_i || eg_d) begin
        own_d   = eg_d;
        last_d  = eg_d;
        rem     = LAT;
        l_addr  = eg_d ? d_addr : i_addr;
        l_size  = eg_d ? d_size : 2'b10;
        l_we    = eg_d && d_we;
        l_wdata = eg_d ? d_wdata : 32'd0;
      end
    end else begin
      if (rem == 1) begin
        if (own_d) begin e_drd = val; e_drv = 1; end
        else       begin e_ird = val; e_irv = 1; end
      end
      rem--;
    end
    @(negedge clk);
  endtask

  task automatic idle_in();
    i_req = 0; d_req = 0; d_we = 0; d_size = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0;
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1;
    step();
    rst = 0;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 32'd0;
    mem[32'h10 >> 2]  = 32'h00500093;
    mem[32'h100 >> 2] = 32'h11223344;
    mem[32'h200 >> 2] = 32'hCAFEF00D;
    rand_rd = 0;
    m_rdata = 0;
    rem = 0; last_d = 1; own_d = 0; l_we = 0;
    l_addr = 0; l_wdata = 0; l_size = 0;
    e_irv = 0; e_drv = 0; e_ird = 0; e_drd = 0;
    idle_in();
    rst = 1;
    @(negedge clk);
    do_reset();

    // fetch
    i_req = 1; i_addr = 32'h10;
    step();
    idle_in();
    chk("t1_maddr", m_addr, 32'h10);
    steps(LAT);
    chk("t1_rvalid", i_rvalid, 1);
    chk("t1_rdata", i_rdata, 32'h00500093);
    step();

    // store
    do_reset();
    d_req = 1; d_we = 1; d_size = 2'b10; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
    step();
    idle_in();
    steps(LAT);
    chk("t2_rvalid", d_rvalid, 1);
    chk("t2_rdata", d_rdata, 0);
    step();
    chk("t2_mem", mem[32'h100 >> 2], 32'hDEADBEEF);

    // continuous tie
    do_reset();
    i_req = 1; i_addr = 32'h20; d_req = 1; d_addr = 32'h24; d_size = 2'b10;
    gq.delete();
    for (int k = 0; k < 40 && gq.size() < 4; k++) step();
    idle_in();
    chk("t3_ngrant", gq.size(), 4);
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_DATA_PRIORITY_EN
      chk("t3_order", k < gq.size() ? 32'(gq[k]) : 32'd2, 1);
`else
      chk("t3_order", k < gq.size() ? 32'(gq[k]) : 32'd2, k % 2);
`endif
    end
    steps(LAT + 1);

    // load byte
    d_req = 1; d_size = 2'b00; d_addr = 32'h103;
    step();
    idle_in();
    steps(LAT);
    chk("t4_rdata", d_rdata, 32'hDEADBEEF);
    step();

    // reset during last busy cycle of a store
    d_req = 1; d_we = 1; d_size = 2'b10; d_addr = 32'h200; d_wdata = 32'h12345678;
    step();
    idle_in();
    steps(LAT - 1);
    rst = 1;
    step();
    rst = 0;
    chk("t5_rvalid", d_rvalid, 0);
    chk("t5_mem", mem[32'h200 >> 2], 32'hCAFEF00D);
    step();

    // back-to-back
    i_req = 1; i_addr = 32'h10;
    step();
    idle_in();
    steps(LAT);
    d_req = 1; d_size = 2'b10; d_addr = 32'h8;
    #2;
    chk("t6_ivalid", i_rvalid, 1);
    chk("t6_dgnt", d_gnt, 1);
    step();
    idle_in();
    steps(LAT + 1);

    // random traffic
    rand_rd = 1;
    for (int k = 0; k < 800; k++) begin
      rst     = ($urandom_range(0, 60) == 0);
      i_req   = $urandom_range(0, 2) != 0;
      d_req   = $urandom_range(0, 2) != 0;
      d_we    = $urandom_range(0, 1);
      d_size  = 2'($urandom_range(0, 3));
      i_addr  = $urandom;
      d_addr  = $urandom;
      d_wdata = $urandom;
      step();
    end
    rst = 0;
    idle_in();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
